// File: rtl/vector_pkg.sv
// Shared definitions for the vector load/store datapath: gather FSM states,
// default widths and the default lane count.
package vector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

  localparam int VECTOR_WIDTH_DEFAULT = 128;
  localparam int DATA_WIDTH_DEFAULT   = 32;
  localparam int ADDR_WIDTH_DEFAULT   = 32;

  // Number of DATA_WIDTH lanes in a VECTOR_WIDTH vector.
  function automatic int lane_count(input int vector_width, input int data_width);
    return vector_width / data_width;
  endfunction

  localparam int LANES_DEFAULT = lane_count(VECTOR_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT);

endpackage

// File: rtl/vector_lane_assembler.sv
// Lane-indexed write port into a VECTOR_WIDTH register. One DATA_WIDTH word is
// written into lane lane_idx when wr_en is high; the other lanes hold.
module vector_lane_assembler #(
  parameter int VECTOR_WIDTH = 128,
  parameter int DATA_WIDTH   = 32,
  parameter int LANE_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANE_W-1:0]       lane_idx,
  input  logic [DATA_WIDTH-1:0]   word,
  input  logic                    wr_en,
  output logic [VECTOR_WIDTH-1:0] vec
);

  localparam int LANES = VECTOR_WIDTH / DATA_WIDTH;

  // Write the selected lane; async reset clears the whole vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_idx == LANE_W'(i)) begin
          vec[i*DATA_WIDTH +: DATA_WIDTH] <= word;
        end
      end
    end
  end

endmodule

// File: rtl/vector_ld_gather.sv
// Vector-load gather: turns one vector-load request into LANES sequential
// scalar reads, assembles the returned words into one vector and strobes
// vector_valid for writeback while holding the CPU stalled during the gather.
module vector_ld_gather
  import vector_pkg::*;
#(
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int ADDR_STRIDE  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_ren_v,
  input  logic [ADDR_WIDTH-1:0]   base_address,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_ren,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic                    stall_cpu,
  output logic [VECTOR_WIDTH-1:0] output_vector,
  output logic                    vector_valid
);

  localparam int LANES = VECTOR_WIDTH / DATA_WIDTH;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  ld_state_t             state_r;
  logic [CNT_W-1:0]      issue_cnt_r;
  logic [CNT_W-1:0]      cap_cnt_r;
  logic [ADDR_WIDTH-1:0] base_q_r;
  logic                  cap_en_s;

  // Gather sequencing: request latch, issue/capture counters and state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      issue_cnt_r <= '0;
      cap_cnt_r   <= '0;
      base_q_r    <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // A request in DONE starts the next gather with no idle gap.
          if (mem_ren_v) begin
            base_q_r    <= base_address;
            issue_cnt_r <= '0;
            cap_cnt_r   <= '0;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          issue_cnt_r <= issue_cnt_r + CNT_W'(1);
          // Read data lags the address by one cycle, so captures start on
          // the second issue cycle.
          if (issue_cnt_r != '0) begin
            cap_cnt_r <= cap_cnt_r + CNT_W'(1);
          end
          if (issue_cnt_r == LAST_LANE) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output decode from the state registers; stall covers the request cycle.
  always_comb begin
    mem_ren      = 1'b0;
    m_address    = '0;
    stall_cpu    = 1'b0;
    vector_valid = 1'b0;
    cap_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        stall_cpu = mem_ren_v;
      end
      ISSUE: begin
        mem_ren   = 1'b1;
        // Address arithmetic wraps modulo 2^ADDR_WIDTH by truncation.
        m_address = base_q_r + (ADDR_WIDTH'(issue_cnt_r) * ADDR_WIDTH'(ADDR_STRIDE));
        stall_cpu = 1'b1;
        cap_en_s  = (issue_cnt_r != '0);
      end
      DRAIN: begin
        stall_cpu = 1'b1;
        cap_en_s  = 1'b1;
      end
      DONE: begin
        vector_valid = 1'b1;
        stall_cpu    = mem_ren_v;
      end
      default: begin
        mem_ren      = 1'b0;
        m_address    = '0;
        stall_cpu    = 1'b0;
        vector_valid = 1'b0;
        cap_en_s     = 1'b0;
      end
    endcase
  end

  vector_lane_assembler #(
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .LANE_W       (CNT_W)
  ) u_assembler (
    .clk      (clk),
    .rst      (rst),
    .lane_idx (cap_cnt_r),
    .word     (mem_rdata),
    .wr_en    (cap_en_s),
    .vec      (output_vector)
  );

endmodule

// File: tb/tb_vector_ld_gather.sv
// Scoreboard bench for vector_ld_gather. Stimulus pushes expected reads,
// expected writeback vectors and the expected stall window; a monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_vector_ld_gather;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_ren_v;
  logic [31:0]  base_address;
  logic [31:0]  mem_rdata;
  logic         mem_ren;
  logic [31:0]  m_address;
  logic         stall_cpu;
  logic [127:0] output_vector;
  logic         vector_valid;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } a_item_t;

  typedef struct {
    int           cyc;
    logic [127:0] vec;
  } v_item_t;

  a_item_t aq[$];
  v_item_t vq[$];
  logic    exp_stall [0:4095];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [127:0] last_vec;
  logic         pend_v = 1'b0;
  logic [31:0]  pend_a = 32'h0;

  localparam logic [127:0] V100 = 128'hA5A5010C_A5A50108_A5A50104_A5A50100;
  localparam logic [127:0] V200 = 128'hA5A5020C_A5A50208_A5A50204_A5A50200;
  localparam logic [127:0] VWRP = 128'hA5A50004_A5A50000_5A5AFFFC_5A5AFFF8;
  localparam logic [127:0] V040 = 128'hA5A5004C_A5A50048_A5A50044_A5A50040;

  vector_ld_gather dut (
    .clk           (clk),
    .rst           (rst),
    .mem_ren_v     (mem_ren_v),
    .base_address  (base_address),
    .mem_rdata     (mem_rdata),
    .mem_ren       (mem_ren),
    .m_address     (m_address),
    .stall_cpu     (stall_cpu),
    .output_vector (output_vector),
    .vector_valid  (vector_valid)
  );

  always #5 clk = ~clk;

  // Cycle counter: cycle n runs from posedge n to posedge n+1.
  always @(posedge clk) cyc = cyc + 1;

  // Memory model: note the read at the falling edge, return data one cycle later.
  always @(negedge clk) begin
    pend_v = mem_ren;
    pend_a = m_address;
  end

  always @(posedge clk) begin
    #1;
    if (pend_v === 1'b1) mem_rdata = pend_a ^ 32'hA5A5_0000;
    else mem_rdata = $urandom;
  end

  // Monitor: compare stall, reads and writebacks against the scoreboard.
  a_item_t ma;
  v_item_t mv;
  always @(negedge clk) begin
    n_cmp++;
    if (stall_cpu !== exp_stall[cyc]) begin
      n_err++;
      $display("FAIL stall cyc=%0d got=%b want=%b", cyc, stall_cpu, exp_stall[cyc]);
    end
    n_cmp++;
    if (mem_ren === 1'b1) begin
      if (aq.size() == 0) begin
        n_err++;
        $display("FAIL read_unexpected cyc=%0d got addr=%h want no read", cyc, m_address);
      end else begin
        ma = aq.pop_front();
        if (ma.cyc != cyc || m_address !== ma.addr) begin
          n_err++;
          $display("FAIL read cyc=%0d got addr=%h want addr=%h at cyc=%0d",
                   cyc, m_address, ma.addr, ma.cyc);
        end
      end
    end else if (mem_ren !== 1'b0 || m_address !== 32'h0) begin
      n_err++;
      $display("FAIL read_idle cyc=%0d got ren=%b addr=%h want 0/0", cyc, mem_ren, m_address);
    end else if (aq.size() > 0 && aq[0].cyc <= cyc) begin
      ma = aq.pop_front();
      n_err++;
      $display("FAIL read_missing cyc=%0d got none want addr=%h", cyc, ma.addr);
    end
    n_cmp++;
    if (vector_valid === 1'b1) begin
      if (vq.size() == 0) begin
        n_err++;
        $display("FAIL valid_unexpected cyc=%0d got vec=%h want no strobe", cyc, output_vector);
      end else begin
        mv = vq.pop_front();
        if (mv.cyc != cyc || output_vector !== mv.vec) begin
          n_err++;
          $display("FAIL vector cyc=%0d got %h want %h at cyc=%0d",
                   cyc, output_vector, mv.vec, mv.cyc);
        end
      end
    end else if (vector_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_x cyc=%0d got=%b want=0", cyc, vector_valid);
    end else if (vq.size() > 0 && vq[0].cyc <= cyc) begin
      mv = vq.pop_front();
      n_err++;
      $display("FAIL valid_missing cyc=%0d got none want %h", cyc, mv.vec);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request in the current cycle and push its expected response.
  task automatic start_req(input logic [31:0] base, input logic [127:0] vec);
    a_item_t a;
    v_item_t v;
    int c0;
    c0 = cyc;
    mem_ren_v    = 1'b1;
    base_address = base;
    for (int i = 0; i < 4; i++) begin
      a.cyc  = c0 + 1 + i;
      a.addr = base + 32'(i) * 32'd4;
      aq.push_back(a);
    end
    v.cyc = c0 + 6;
    v.vec = vec;
    vq.push_back(v);
    for (int i = 0; i < 6; i++) exp_stall[c0 + i] = 1'b1;
  endtask

  // Full gather; returns positioned in its DONE cycle.
  task automatic run_gather(input logic [31:0] base, input logic [127:0] vec);
    start_req(base, vec);
    step();
    mem_ren_v    = 1'b0;
    base_address = 32'h0;
    repeat (5) step();
    last_vec = vec;
  endtask

  task automatic check_quiet(input string name);
    n_cmp++;
    if (mem_ren !== 1'b0 || m_address !== 32'h0 || stall_cpu !== 1'b0 ||
        vector_valid !== 1'b0 || output_vector !== 128'h0) begin
      n_err++;
      $display("FAIL %s got ren=%b addr=%h stall=%b valid=%b vec=%h want all 0",
               name, mem_ren, m_address, stall_cpu, vector_valid, output_vector);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) exp_stall[i] = 1'b0;
    rst          = 1'b1;
    mem_ren_v    = 1'b0;
    base_address = 32'h0;
    mem_rdata    = 32'h0;
    last_vec     = 128'h0;
    #1 rst = 1'b0;
    repeat (2) step();
    check_quiet("reset_state");
    rst = 1'b1;
    repeat (2) step();

    // Basic gather.
    run_gather(32'h0000_0100, V100);
    repeat (2) step();

    // Back-to-back: second request in the DONE cycle.
    run_gather(32'h0000_0100, V100);
    run_gather(32'h0000_0200, V200);
    repeat (2) step();

    // Address wrap.
    run_gather(32'hFFFF_FFF8, VWRP);
    repeat (2) step();

    // Reset in cycle 3 of a gather aborts everything immediately.
    start_req(32'h0000_0100, V100);
    step();
    mem_ren_v    = 1'b0;
    base_address = 32'h0;
    repeat (2) step();
    rst = 1'b0;
    while (aq.size() > 0 && aq[$].cyc >= cyc) void'(aq.pop_back());
    while (vq.size() > 0 && vq[$].cyc >= cyc) void'(vq.pop_back());
    for (int i = 0; i < 8; i++) exp_stall[cyc + i] = 1'b0;
    last_vec = 128'h0;
    #1;
    check_quiet("reset_mid_gather");
    repeat (2) step();
    rst = 1'b1;
    step();
    run_gather(32'h0000_0040, V040);
    repeat (2) step();

    // Request pulsed during ISSUE is ignored.
    start_req(32'h0000_0100, V100);
    step();
    mem_ren_v    = 1'b0;
    base_address = 32'h0;
    step();
    mem_ren_v    = 1'b1;
    base_address = 32'h0000_0300;
    step();
    mem_ren_v    = 1'b0;
    base_address = 32'h0;
    repeat (3) step();
    last_vec = V100;
    repeat (2) step();

    // Idle quiescence with random read data.
    repeat (20) begin
      step();
      #2;
      n_cmp++;
      if (output_vector !== last_vec) begin
        n_err++;
        $display("FAIL idle_vector cyc=%0d got %h want %h", cyc, output_vector, last_vec);
      end
    end

    step();
    n_cmp++;
    if (aq.size() != 0 || vq.size() != 0) begin
      n_err++;
      $display("FAIL leftover got reads=%0d vectors=%0d want 0/0", aq.size(), vq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
